// File: rtl/rr_arb4_if.sv
// Request/grant bundle between the four register-file write requesters and rr_arb4.
// Signal directions are named from the arbiter's point of view.
interface rr_arb4_if;
    logic [3:0] i_req;
    logic       i_release;
    logic [3:0] o_gnt;
    logic [1:0] o_gnt_idx;
    logic       o_gnt_valid;
    logic       o_timeout;

    modport master (
        output i_req, i_release,
        input  o_gnt, o_gnt_idx, o_gnt_valid, o_timeout
    );

    modport slave (
        input  i_req, i_release,
        output o_gnt, o_gnt_idx, o_gnt_valid, o_timeout
    );
endinterface

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter for a shared register-file write port, with registered outputs.
// Optional forced release after 16 held cycles is enabled by defining ARB_TIMEOUT_EN.
module rr_arb4 (
    input  logic        clk,
    input  logic        reset,
    rr_arb4_if.slave    bus
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_ptr, w_ptr_nxt;
    logic [1:0]  r_gnt_idx, w_gnt_idx_nxt;
    logic        r_gnt_valid, w_gnt_valid_nxt;
    logic [3:0]  r_gnt, w_gnt_nxt;
    logic [2:0]  w_pick;
    logic        w_end;
`ifdef ARB_TIMEOUT_EN
    logic [3:0]  r_hold, w_hold_nxt;
    logic        r_timeout, w_timeout_nxt;
    logic        w_force;
`endif

    // Returns {found, index}: first requester at or after ptr, wrapping mod 4.
    function automatic logic [2:0] f_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        f_pick = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) f_pick = {1'b1, idx};
        end
    endfunction

    assign w_pick = f_pick(bus.i_req, r_ptr);
    assign w_end  = bus.i_release | ~bus.i_req[r_gnt_idx];
`ifdef ARB_TIMEOUT_EN
    assign w_force = (r_hold == 4'd15) & ~w_end;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_gnt_valid_nxt = r_gnt_valid;
`ifdef ARB_TIMEOUT_EN
        w_hold_nxt      = r_hold;
        w_timeout_nxt   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_pick[2]) begin
                    w_state_nxt     = S_BUSY;
                    w_gnt_idx_nxt   = w_pick[1:0];
                    w_ptr_nxt       = w_pick[1:0] + 2'd1;
                    w_gnt_valid_nxt = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    w_hold_nxt      = 4'd0;
`endif
                end
            end
            S_BUSY: begin
`ifdef ARB_TIMEOUT_EN
                if (w_end | w_force) begin
                    w_timeout_nxt = w_force;
`else
                if (w_end) begin
`endif
                    // Pointer already sits past the owner, so the owner is searched last.
                    if (w_pick[2]) begin
                        w_gnt_idx_nxt = w_pick[1:0];
                        w_ptr_nxt     = w_pick[1:0] + 2'd1;
`ifdef ARB_TIMEOUT_EN
                        w_hold_nxt    = 4'd0;
`endif
                    end else begin
                        w_state_nxt     = S_IDLE;
                        w_gnt_valid_nxt = 1'b0;
                    end
                end else begin
`ifdef ARB_TIMEOUT_EN
                    w_hold_nxt = r_hold + 4'd1;
`endif
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_gnt_valid_nxt = 1'b0;
            end
        endcase
        w_gnt_nxt = w_gnt_valid_nxt ? (4'b0001 << w_gnt_idx_nxt) : 4'b0000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= 2'd0;
            r_gnt_idx   <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_gnt       <= 4'b0000;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_gnt       <= w_gnt_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold    <= 4'd0;
            r_timeout <= 1'b0;
        end else begin
            r_hold    <= w_hold_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end
    assign bus.o_timeout = r_timeout;
`else
    assign bus.o_timeout = 1'b0;
`endif

    assign bus.o_gnt       = r_gnt;
    assign bus.o_gnt_idx   = r_gnt_idx;
    assign bus.o_gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_rr_arb4.sv
// Scoreboard bench for rr_arb4: stimulus pushes predicted outputs, a negedge monitor compares.
// Honours ARB_TIMEOUT_EN in its reference model.
module tb_rr_arb4;

    logic clk = 1'b0;
    logic reset;
    rr_arb4_if bus();

    rr_arb4 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] idx;
        logic       to;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model: owner (-1 = none), search start, last owner index, cycles held.
    int   m_owner, m_ptr, m_idx, m_held;
    logic m_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_idx   = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic rl);
        bit ending;
        int pick;
        m_to = 1'b0;
        if (m_owner < 0) begin
            ending = 1'b1;
        end else begin
            ending = rl || !r[m_owner];
`ifdef ARB_TIMEOUT_EN
            if (!ending && m_held == 16) begin
                ending = 1'b1;
                m_to   = 1'b1;
            end
`endif
            if (!ending) m_held++;
        end
        if (ending) begin
            pick = -1;
            for (int k = 0; k < 4; k++)
                if (pick < 0 && r[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
            if (pick >= 0) begin
                m_owner = pick;
                m_idx   = pick;
                m_ptr   = (pick + 1) % 4;
                m_held  = 1;
            end else begin
                m_owner = -1;
            end
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic rl);
        exp_t e;
        bus.i_req     = r;
        bus.i_release = rl;
        model_step(r, rl);
        @(posedge clk);
        #1;
        e.v   = (m_owner >= 0);
        e.idx = 2'(m_idx);
        e.to  = m_to;
        q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},       32'(bus.o_gnt),       32'h0);
        check({tag, "_gnt_valid"}, 32'(bus.o_gnt_valid), 32'h0);
        check({tag, "_gnt_idx"},   32'(bus.o_gnt_idx),   32'h0);
        check({tag, "_timeout"},   32'(bus.o_timeout),   32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        bus.i_req     = 4'b0000;
        bus.i_release = 1'b0;
        reset = 1'b0;
    endtask

    // Monitor: outputs are registered and stable at the falling edge.
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] g;
        while (q.size() > 0) begin
            e = q.pop_front();
            g = e.v ? (4'b0001 << e.idx) : 4'b0000;
            check("gnt_valid", 32'(bus.o_gnt_valid), 32'(e.v));
            check("gnt",       32'(bus.o_gnt),       32'(g));
            check("gnt_idx",   32'(bus.o_gnt_idx),   32'(e.idx));
            check("timeout",   32'(bus.o_timeout),   32'(e.to));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        bus.i_req     = 4'b0000;
        bus.i_release = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // First grant after reset searches from 0; pointer moves past the winner.
        drive(4'b1010, 1'b0);
        check("first_gnt", 32'(bus.o_gnt), 32'h2);
        check("ptr_after_first", 32'(dut.r_ptr), 32'h2);
        drive(4'b0000, 1'b1);

        // All requesting, release every third cycle: back-to-back rotation.
        do_reset();
        for (int c = 0; c < 15; c++) drive(4'b1111, (c % 3) == 2);

        // Sole requester re-granted after release, then idle.
        do_reset();
        drive(4'b0100, 1'b0);
        drive(4'b0100, 1'b1);
        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b0);

        // Owner drops its request without release.
        do_reset();
        drive(4'b1000, 1'b0);
        drive(4'b0001, 1'b0);
        drive(4'b0001, 1'b0);

        // Asynchronous reset between edges while busy.
        do_reset();
        drive(4'b0110, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rst_gnt",       32'(bus.o_gnt),       32'h0);
        check("async_rst_gnt_valid", 32'(bus.o_gnt_valid), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(4'b1001, 1'b0);
        check("post_rst_idx", 32'(bus.o_gnt_idx), 32'h0);

        // Long hold: forced hand-off only with the timeout feature.
        do_reset();
        for (int c = 0; c < 100; c++) drive(4'b0011, 1'b0);

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 400; c++)
            drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
